// File: rtl/uart_dbg_mem_server_if.sv
// uart_dbg_mem_server_if: instruction fetch and data access bus between core and memory server
interface uart_dbg_mem_server_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  instr_req_i;
  logic [ADDR_WIDTH-1:0] instr_addr_i;
  logic                  instr_gnt_o;
  logic                  instr_rvalid_o;
  logic [31:0]           instr_rdata_o;
  logic                  data_req_i;
  logic                  data_we_i;
  logic [31:0]           data_addr_i;
  logic [3:0]            data_be_i;
  logic [31:0]           data_wdata_i;
  logic                  data_gnt_o;
  logic                  data_rvalid_o;
  logic [31:0]           data_rdata_o;
  modport master (
    output instr_req_i, instr_addr_i, data_req_i, data_we_i, data_addr_i, data_be_i, data_wdata_i,
    input  instr_gnt_o, instr_rvalid_o, instr_rdata_o, data_gnt_o, data_rvalid_o, data_rdata_o
  );
  modport slave (
    input  instr_req_i, instr_addr_i, data_req_i, data_we_i, data_addr_i, data_be_i, data_wdata_i,
    output instr_gnt_o, instr_rvalid_o, instr_rdata_o, data_gnt_o, data_rvalid_o, data_rdata_o
  );
endinterface

// File: rtl/uart_dbg_mem_server.sv
// uart_dbg_mem_server: debugger-loaded instruction/data memory server with throttled fetch engine
module uart_dbg_mem_server #(
  parameter int IDEPTH     = 32,
  parameter int DDEPTH     = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int LAT_W      = 4
) (
  input  logic        core_clk,
  input  logic        rst,
  input  logic [7:0]  reg_addr,
  input  logic [31:0] reg_wr_data,
  input  logic        reg_wr_en,
  input  logic        reg_rd_en,
  output logic [31:0] reg_rd_data,
  output logic        reg_rd_done,
  input  logic        start_test,
  output logic        test_running,
  output logic        test_done,
  uart_dbg_mem_server_if.slave bus
);
  localparam int IW = $clog2(IDEPTH);
  localparam int DW = $clog2(DDEPTH);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state;
  logic [31:0] imem [IDEPTH];
  logic [31:0] dmem [DDEPTH];
  logic [LAT_W-1:0] latency, wait_cnt;
  logic [15:0] inst_limit, fetch_count;
  logic addr_err, busy_wr_err, lat_err;
  logic [IW-1:0] lat_idx;
  logic [ADDR_WIDTH-1:0] iaddr;
  logic [31:0] ia, rd_mux;
  logic [DW-1:0] d_idx;
  logic wr_ctrl, start, abort, wr_imem, wr_dmem, grant, i_oor, d_oor, limit_hit, unused;
  assign iaddr     = bus.instr_addr_i;
  assign ia        = 32'(iaddr);
  assign wr_ctrl   = reg_wr_en && reg_addr == 8'h00;
  assign start     = start_test | (wr_ctrl & reg_wr_data[0]);
  assign abort     = wr_ctrl & reg_wr_data[1];
  assign wr_imem   = reg_wr_en && reg_addr[7:6] == 2'b01;
  assign wr_dmem   = reg_wr_en && reg_addr[7:6] == 2'b10;
  assign i_oor     = ia[31:2] >= 30'(IDEPTH) || ia[1:0] != 2'b00;
  assign d_oor     = bus.data_addr_i[31:2] >= 30'(DDEPTH);
  assign d_idx     = bus.data_addr_i[DW+1:2];
  assign limit_hit = inst_limit != 16'd0 && fetch_count == inst_limit;
  assign grant     = state == RUN && bus.instr_req_i && wait_cnt >= latency && !bus.instr_gnt_o;
  assign bus.data_gnt_o = bus.data_req_i & test_running;
  assign unused    = ^bus.data_addr_i[1:0];
  always_comb
    rd_mux = reg_addr[7:6] == 2'b01 ? imem[reg_addr[IW-1:0]] :
             reg_addr[7:6] == 2'b10 ? dmem[reg_addr[DW-1:0]] :
             reg_addr == 8'h01      ? {28'd0, busy_wr_err, addr_err, state} :
             reg_addr == 8'h02      ? 32'(latency) :
             reg_addr == 8'h03      ? {16'd0, inst_limit} :
             reg_addr == 8'h04      ? {16'd0, fetch_count} : 32'd0;
  // memory windows are frozen for the debugger while a test owns them
  always_ff @(posedge core_clk) begin
    if (wr_imem && !test_running) imem[reg_addr[IW-1:0]] <= reg_wr_data;
    if (wr_dmem && !test_running) dmem[reg_addr[DW-1:0]] <= reg_wr_data;
    else if (bus.data_gnt_o && bus.data_we_i && !d_oor)
      for (int b = 0; b < 4; b++)
        if (bus.data_be_i[b]) dmem[d_idx][8*b +: 8] <= bus.data_wdata_i[8*b +: 8];
  end
  always_ff @(posedge core_clk or posedge rst)
    if (rst) begin
      state              <= IDLE;
      test_running       <= 1'b0;
      test_done          <= 1'b0;
      reg_rd_data        <= '0;
      reg_rd_done        <= 1'b0;
      latency            <= '0;
      wait_cnt           <= '0;
      inst_limit         <= 16'd2;
      fetch_count        <= '0;
      addr_err           <= 1'b0;
      busy_wr_err        <= 1'b0;
      lat_idx            <= '0;
      lat_err            <= 1'b0;
      bus.instr_gnt_o    <= 1'b0;
      bus.instr_rvalid_o <= 1'b0;
      bus.instr_rdata_o  <= '0;
      bus.data_rvalid_o  <= 1'b0;
      bus.data_rdata_o   <= '0;
    end else begin
      reg_rd_done        <= reg_rd_en;
      reg_rd_data        <= reg_rd_en ? rd_mux : '0;
      bus.instr_gnt_o    <= grant;
      bus.instr_rvalid_o <= bus.instr_gnt_o;
      bus.instr_rdata_o  <= bus.instr_gnt_o ? (lat_err ? 32'h0000_0013 : imem[lat_idx]) : '0;
      bus.data_rvalid_o  <= bus.data_gnt_o;
      bus.data_rdata_o   <= bus.data_gnt_o && !bus.data_we_i && !d_oor ? dmem[d_idx] : '0;
      if (reg_wr_en && reg_addr == 8'h02) latency <= reg_wr_data[LAT_W-1:0];
      if (reg_wr_en && reg_addr == 8'h03) inst_limit <= reg_wr_data[15:0];
      if (reg_wr_en && reg_addr == 8'h01) begin
        addr_err    <= 1'b0;
        busy_wr_err <= 1'b0;
      end
      if ((grant && i_oor) || (bus.data_gnt_o && d_oor)) addr_err <= 1'b1;
      if ((wr_imem || wr_dmem) && test_running) busy_wr_err <= 1'b1;
      if (grant) begin
        fetch_count <= fetch_count + 16'd1;
        wait_cnt    <= '0;
        lat_idx     <= ia[IW+1:2];
        lat_err     <= i_oor;
      end else if (state == RUN && bus.instr_req_i && !bus.instr_gnt_o && wait_cnt < latency)
        wait_cnt <= wait_cnt + 1'b1;
      // an outstanding grant always owes its rvalid before the test may end
      case (state)
        IDLE: if (start) begin
          state        <= RUN;
          test_running <= 1'b1;
          fetch_count  <= '0;
          wait_cnt     <= '0;
        end
        RUN: if (limit_hit || abort) state <= DRAIN;
        DRAIN: if (!bus.instr_gnt_o) begin
          state        <= DONE;
          test_running <= 1'b0;
          test_done    <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          test_done <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_uart_dbg_mem_server.sv
// tb_uart_dbg_mem_server: randomized self-checking bench against an array/queue reference model
module tb_uart_dbg_mem_server;
  logic core_clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] reg_addr = '0;
  logic [31:0] reg_wr_data = '0;
  logic reg_wr_en = 1'b0, reg_rd_en = 1'b0, start_test = 1'b0;
  logic [31:0] reg_rd_data;
  logic reg_rd_done, test_running, test_done;
  int vectors = 0, miscompares = 0, done_cnt = 0, runs = 0;
  bit derr;
  logic [31:0] m_imem [32];
  logic [31:0] m_dmem [16];
  uart_dbg_mem_server_if #(.ADDR_WIDTH(8)) bus ();
  uart_dbg_mem_server #(.IDEPTH(32), .DDEPTH(16), .ADDR_WIDTH(8), .LAT_W(4)) dut (
    .core_clk(core_clk), .rst(rst), .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
    .reg_wr_en(reg_wr_en), .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data),
    .reg_rd_done(reg_rd_done), .start_test(start_test), .test_running(test_running),
    .test_done(test_done), .bus(bus)
  );
  always #5 core_clk = ~core_clk;
  always @(negedge core_clk) if (test_done) done_cnt++;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  task automatic reg_wr(input logic [7:0] a, input logic [31:0] d);
    reg_addr = a;
    reg_wr_data = d;
    reg_wr_en = 1'b1;
    tick();
    reg_wr_en = 1'b0;
  endtask

  task automatic reg_chk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    reg_addr = a;
    reg_rd_en = 1'b1;
    tick();
    reg_rd_en = 1'b0;
    check({tag, "_done"}, 32'(reg_rd_done), 1);
    check(tag, reg_rd_data, exp);
  endtask

  function automatic logic [31:0] iexp(input logic [7:0] a);
    int w;
    w = int'(a) / 4;
    return (w >= 32 || int'(a) % 4 != 0) ? 32'h0000_0013 : m_imem[w];
  endfunction

  // the grant must appear LATENCY+1 edges after req is first sampled, data one edge later
  task automatic fetch(input logic [7:0] a, input int lat, input logic [31:0] exp);
    int k;
    k = 0;
    bus.instr_req_i = 1'b1;
    bus.instr_addr_i = a;
    do begin
      tick();
      k++;
    end while (!bus.instr_gnt_o && k < 40);
    check("gnt_latency", 32'(k), 32'(lat + 1));
    bus.instr_req_i = 1'b0;
    tick();
    check("rvalid", 32'(bus.instr_rvalid_o), 1);
    check("rdata", bus.instr_rdata_o, exp);
  endtask

  task automatic do_run(input int lat, input int lim, input int mode);
    logic [7:0] a;
    bit err;
    int gap;
    err = 1'b0;
    reg_wr(8'h02, 32'(lat));
    reg_wr(8'h03, 32'(lim));
    reg_wr(8'h00, 32'd1);
    check("run_entry", 32'(test_running), 1);
    for (int i = 0; i < lim; i++) begin
      gap = mode == 0 ? int'($urandom_range(0, 2)) : 0;
      a = mode == 1 ? 8'(i * 4) : mode == 2 ? 8'h84 :
          $urandom_range(0, 5) == 0 ? 8'($urandom) : 8'($urandom_range(0, 31) * 4);
      if (int'(a) / 4 >= 32 || int'(a) % 4 != 0) err = 1'b1;
      repeat (gap) tick();
      fetch(a, lat, iexp(a));
    end
    check("drain_running", 32'(test_running), 1);
    check("drain_no_done", 32'(test_done), 0);
    tick();
    check("done_pulse", 32'(test_done), 1);
    check("done_stopped", 32'(test_running), 0);
    tick();
    check("done_clear", 32'(test_done), 0);
    runs++;
    reg_chk("fetch_count", 8'h04, 32'(lim));
    reg_chk("status_err", 8'h01, err ? 32'h4 : 32'h0);
    reg_wr(8'h01, 32'd0);
    reg_chk("status_clr", 8'h01, 32'h0);
  endtask

  task automatic dacc(input bit we, input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    logic [31:0] exp, mask;
    int idx;
    idx = int'(a / 4);
    exp = '0;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    if (idx >= 16) derr = 1'b1;
    else if (we) m_dmem[idx] = (m_dmem[idx] & ~mask) | (wd & mask);
    else exp = m_dmem[idx];
    bus.data_req_i = 1'b1;
    bus.data_we_i = we;
    bus.data_addr_i = a;
    bus.data_be_i = be;
    bus.data_wdata_i = wd;
    #1;
    check("data_gnt", 32'(bus.data_gnt_o), 1);
    @(posedge core_clk);
    #1;
    bus.data_req_i = 1'b0;
    check("data_rvalid", 32'(bus.data_rvalid_o), 1);
    check("data_rdata", bus.data_rdata_o, exp);
  endtask

  initial begin
    logic [31:0] q[$];
    logic [7:0] a;
    int k;
    bus.instr_req_i = 1'b0;
    bus.instr_addr_i = '0;
    bus.data_req_i = 1'b0;
    bus.data_we_i = 1'b0;
    bus.data_addr_i = '0;
    bus.data_be_i = '0;
    bus.data_wdata_i = '0;
    repeat (2) tick();
    check("rst_flags", {26'd0, bus.instr_gnt_o, bus.instr_rvalid_o, bus.data_rvalid_o,
                        test_running, test_done, reg_rd_done}, 0);
    check("rst_irdata", bus.instr_rdata_o, 0);
    check("rst_drdata", bus.data_rdata_o, 0);
    check("rst_rddata", reg_rd_data, 0);
    rst = 1'b0;
    tick();
    reg_chk("status_rst", 8'h01, 0);
    reg_chk("latency_rst", 8'h02, 0);
    reg_chk("limit_rst", 8'h03, 2);
    reg_chk("count_rst", 8'h04, 0);
    for (int i = 0; i < 32; i++) begin
      m_imem[i] = i < 3 ? 32'h11 * 32'(i + 1) : $urandom;
      reg_wr(8'h40 + 8'(i), m_imem[i]);
    end
    for (int i = 0; i < 16; i++) begin
      m_dmem[i] = $urandom;
      reg_wr(8'h80 + 8'(i), m_dmem[i]);
    end
    reg_chk("imem_rd", 8'h47, m_imem[7]);
    reg_chk("imem_wrap", 8'h63, m_imem[3]);
    reg_chk("dmem_wrap", 8'h92, m_dmem[2]);
    reg_chk("unmapped", 8'h05, 0);
    do_run(3, 3, 1);
    for (int r = 0; r < 8; r++) do_run(int'($urandom_range(0, 4)), int'($urandom_range(1, 5)), 0);
    do_run(0, 1, 2);
    // LATENCY 0, unlimited: a grant on every other edge while req stays high
    reg_wr(8'h02, 0);
    reg_wr(8'h03, 0);
    start_test = 1'b1;
    tick();
    start_test = 1'b0;
    check("b2b_running", 32'(test_running), 1);
    a = 8'h0;
    bus.instr_req_i = 1'b1;
    bus.instr_addr_i = a;
    for (int e = 1; e <= 11; e++) begin
      tick();
      check("b2b_gnt", 32'(bus.instr_gnt_o), 32'(e % 2));
      check("b2b_rvalid", 32'(bus.instr_rvalid_o), 32'(e % 2 == 0));
      if (e % 2 == 0) check("b2b_rdata", bus.instr_rdata_o, q.pop_front());
      else begin
        q.push_back(iexp(a));
        a = a + 8'd4;
        bus.instr_addr_i = a;
      end
    end
    bus.instr_req_i = 1'b0;
    reg_wr(8'h00, 32'h2);
    check("abort_rvalid", 32'(bus.instr_rvalid_o), 1);
    check("abort_rdata", bus.instr_rdata_o, q.pop_front());
    check("abort_drain", 32'(test_running), 1);
    tick();
    check("abort_done", 32'(test_done), 1);
    runs++;
    reg_chk("b2b_count", 8'h04, 6);
    // data port with byte enables, out-of-range access and a blocked window write
    derr = 1'b0;
    reg_wr(8'h00, 32'h1);
    dacc(1'b1, 32'h8, 4'hF, 32'hAABB_CCDD);
    dacc(1'b1, 32'h8, 4'h5, 32'h1122_3344);
    dacc(1'b0, 32'h8, 4'h0, 32'h0);
    dacc(1'b0, 32'h100, 4'hF, 32'h0);
    for (int i = 0; i < 24; i++)
      dacc(1'($urandom), 32'($urandom_range(0, 19) * 4), 4'($urandom), $urandom);
    reg_wr(8'h45, 32'hDEAD_BEEF);
    start_test = 1'b1;
    tick();
    start_test = 1'b0;
    check("start_ignored", 32'(test_running), 1);
    reg_chk("status_run", 8'h01, {28'd0, 1'b1, derr, 2'b01});
    reg_wr(8'h00, 32'h2);
    check("data_drain", 32'(test_running), 1);
    tick();
    check("data_done", 32'(test_done), 1);
    runs++;
    tick();
    reg_chk("busy_kept", 8'h45, m_imem[5]);
    reg_chk("status_busy", 8'h01, {28'd0, 1'b1, derr, 2'b00});
    for (int i = 0; i < 16; i++) reg_chk("dmem_final", 8'h80 + 8'(i), m_dmem[i]);
    bus.data_req_i = 1'b1;
    #1;
    check("dgnt_idle", 32'(bus.data_gnt_o), 0);
    bus.data_req_i = 1'b0;
    reg_wr(8'h00, 32'h2);
    check("abort_idle", 32'(test_running), 0);
    // asynchronous reset while a grant is on the bus
    reg_wr(8'h02, 5);
    reg_wr(8'h03, 0);
    reg_wr(8'h00, 32'h1);
    bus.instr_req_i = 1'b1;
    bus.instr_addr_i = 8'h10;
    k = 0;
    do begin
      tick();
      k++;
    end while (!bus.instr_gnt_o && k < 40);
    check("pre_rst_gnt", 32'(bus.instr_gnt_o), 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async", {28'd0, bus.instr_gnt_o, bus.instr_rvalid_o, test_running, test_done}, 0);
    bus.instr_req_i = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    reg_chk("status_after_rst", 8'h01, 0);
    reg_chk("latency_after_rst", 8'h02, 0);
    reg_chk("limit_after_rst", 8'h03, 2);
    check("done_pulses", 32'(done_cnt), 32'(runs));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
